ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Execute-to-memory pipeline register. Sits directly upstream of the memory stage and feeds it every operand and control field it consumes.
- Supports stall (hold), flush (bubble insert), sticky halt drain and sticky error flag.
- All outputs are registered; memory stage sees values one cycle after the execute stage presents them.

Parameters:
- DRAIN_CYCLES, 2, cycles after a halt is latched before haltDone asserts (lets MEM and WB retire).
- NOP_INSTR, 16'h0800, instruction word driven on a bubble.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- validIn  in  1  execute stage presents a real instruction
- stall  in  1  hold all registers this cycle
- flush  in  1  replace incoming instruction with bubble
- aluIn, setValIn, reg1In, reg2In, nextPcIn, instrIn  in  16 each  datapath fields
- memEnIn, memWrtIn, regWrtIn, haltIn  in  1 each  control fields
- regWrtSrcIn  in  3  writeback source select
- writeRegIn  in  3  destination register
- aluOut, setVal, reg1Data, reg2Data, nextPc, instr  out  16 each  registered fields
- memEn, memWrt, regWrt, halt  out  1 each  registered control
- regWrtSrc, writeReg  out  3 each
- validOut  out  1  registered validity
- err  out  1  sticky error
- haltDone  out  1  drain complete, pipeline may stop

Behaviour:
- Reset (rst=0, async): all data outputs 0; instr=NOP_INSTR; all control 0; validOut=0; err=0; haltDone=0; FSM=RUN; drain counter=0.
- Per-edge priority: reset > flush > stall > load.
- Load: every output takes its input; validOut=validIn. Control outputs are ANDed with validIn, so invalid input never writes memory or registers.
- Flush: bubble loaded regardless of stall. Bubble means:
  - memEn, memWrt, regWrt, halt, validOut all 0
  - instr=NOP_INSTR
  - data fields 0
- Stall without flush: all field registers hold. FSM and drain counter also hold.
- Error: err sets when a loaded valid entry has regWrtSrcIn==3'h7. err stays set until reset. err does not itself block loading.
- FSM:
  - RUN: on a load with validIn & haltIn, go to DRAIN and clear the counter. The halting entry itself passes through with halt=1.
  - DRAIN: every non-stall edge loads a bubble, whatever the inputs are, and increments the counter. When the counter reaches DRAIN_CYCLES-1, go to DONE.
  - DONE: haltDone=1. Bubbles are held; inputs are ignored until reset.
- Halt and flush in the same cycle: flush wins. The halt is squashed and the FSM stays in RUN.
- Halt arriving during DRAIN or DONE: ignored.
- Counter width is clog2(DRAIN_CYCLES)+1 and it never wraps. DRAIN_CYCLES=1 goes to DONE on the first drain edge.
- Reset mid-drain: returns to RUN; haltDone drops immediately.

Optional Feature:
- Macro EX_MEM_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubbleCnt (16 bits), reset to 0.
  - Increments on each edge that loads a bubble (flush, invalid input, or drain) and not on stalled edges.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared include file holds:
  - the NOP_INSTR encoding
  - regWrtSrc codes 0..6 and the illegal code 7
  - FSM state encodings RUN=2'd0, DRAIN=2'd1, DONE=2'd2
- One natural sub-module, pipe_field_reg: a parameterised-width register with async active-low reset, hold enable, and bubble-value load. Instantiate it once per field group.

Test Plan:
- Load and latency: validIn=1, aluIn=16'h1234, regWrt=1, writeReg=3, no stall → next edge aluOut=16'h1234, regWrt=1, writeReg=3, validOut=1.
- Stall and flush: during stall=1 for 3 cycles, changing inputs → outputs unchanged. Then flush=1 with stall=1 → memEn=0, regWrt=0, instr=16'h0800.
- Invalid input gating: validIn=0, memWrtIn=1 → memWrt=0, validOut=0.
- Halt drain, DRAIN_CYCLES=2:
  - Halting entry loaded → halt=1.
  - Next two non-stall edges load bubbles despite validIn=1.
  - haltDone=1 after the 2nd drain edge.
  - A stall inserted mid-drain delays haltDone by exactly 1 cycle.
- Halt and flush together → halt=0, FSM stays RUN, haltDone stays 0.
- Error and reset:
  - Valid load with regWrtSrcIn=7 → err=1.
  - err persists across later legal loads.
  - Async rst=0 mid-drain → err=0, haltDone=0, instr=16'h0800 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared encodings for the execute-to-memory pipeline register:
// the bubble instruction word, writeback source codes and FSM states.
package ex_mem_reg_pkg;

  localparam logic [15:0] NOP_INSTR_ENC = 16'h0800;

  // Writeback source select; code 7 is illegal and raises the sticky error.
  typedef enum logic [2:0] {
    WSRC_ALU     = 3'd0,
    WSRC_SET     = 3'd1,
    WSRC_MEM     = 3'd2,
    WSRC_PC      = 3'd3,
    WSRC_REG1    = 3'd4,
    WSRC_REG2    = 3'd5,
    WSRC_IMM     = 3'd6,
    WSRC_ILLEGAL = 3'd7
  } wb_src_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_field_reg.sv
// Parameterised pipeline field register: async active-low reset to RST_VAL,
// holds when en is low, otherwise loads either d or the bubble value.
module pipe_field_reg #(
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] bubble_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] field_q;
  logic [WIDTH-1:0] field_d;

  // Next value: hold, bubble or fresh load.
  always_comb begin
    field_d = field_q;
    if (en) begin
      field_d = bubble ? bubble_val : d;
    end
  end

  // Field storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q <= RST_VAL;
    end else begin
      field_q <= field_d;
    end
  end

  assign q = field_q;

endmodule

// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline register with stall, flush, sticky error and
// halt drain sequencing.
// Optional bubble counter output enabled by defining EX_MEM_BUBBLE_CNT_EN.
//
// state | meaning
// RUN   | normal operation, entries pass through
// DRAIN | halt latched, bubbles inserted while MEM/WB retire
// DONE  | drain complete, haltDone high, bubbles held until reset
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [15:0] NOP_INSTR    = NOP_INSTR_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] aluIn,
  input  logic [15:0] setValIn,
  input  logic [15:0] reg1In,
  input  logic [15:0] reg2In,
  input  logic [15:0] nextPcIn,
  input  logic [15:0] instrIn,
  input  logic        memEnIn,
  input  logic        memWrtIn,
  input  logic        regWrtIn,
  input  logic        haltIn,
  input  logic [2:0]  regWrtSrcIn,
  input  logic [2:0]  writeRegIn,
  output logic [15:0] aluOut,
  output logic [15:0] setVal,
  output logic [15:0] reg1Data,
  output logic [15:0] reg2Data,
  output logic [15:0] nextPc,
  output logic [15:0] instr,
  output logic        memEn,
  output logic        memWrt,
  output logic        regWrt,
  output logic        halt,
  output logic [2:0]  regWrtSrc,
  output logic [2:0]  writeReg,
  output logic        validOut,
  output logic        err,
  output logic        haltDone
`ifdef EX_MEM_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubbleCnt
`endif
);

  localparam int              CNT_W    = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_done_q, halt_done_d;
  logic             err_q, err_d;

  logic load_en;
  logic field_en;
  logic bubble_sel;

  logic [79:0] data_in, data_q;
  logic [10:0] ctrl_in, ctrl_q;

  // Flush overrides stall; once DONE the fields are frozen on a bubble.
  always_comb begin
    load_en    = flush || !stall;
    field_en   = load_en && (state_q != ST_DONE);
    bubble_sel = flush || (state_q != ST_RUN);
  end

  assign data_in = {aluIn, setValIn, reg1In, reg2In, nextPcIn};
  assign ctrl_in = {memEnIn & validIn, memWrtIn & validIn, regWrtIn & validIn,
                    haltIn & validIn, regWrtSrcIn, writeRegIn, validIn};

  pipe_field_reg #(.WIDTH(80), .RST_VAL('0)) u_data_reg (
    .clk       (clk),
    .rst_n     (rst),
    .en        (field_en),
    .bubble    (bubble_sel),
    .d         (data_in),
    .bubble_val('0),
    .q         (data_q)
  );

  pipe_field_reg #(.WIDTH(16), .RST_VAL(NOP_INSTR)) u_instr_reg (
    .clk       (clk),
    .rst_n     (rst),
    .en        (field_en),
    .bubble    (bubble_sel),
    .d         (instrIn),
    .bubble_val(NOP_INSTR),
    .q         (instr)
  );

  pipe_field_reg #(.WIDTH(11), .RST_VAL('0)) u_ctrl_reg (
    .clk       (clk),
    .rst_n     (rst),
    .en        (field_en),
    .bubble    (bubble_sel),
    .d         (ctrl_in),
    .bubble_val('0),
    .q         (ctrl_q)
  );

  assign {aluOut, setVal, reg1Data, reg2Data, nextPc} = data_q;
  assign {memEn, memWrt, regWrt, halt, regWrtSrc, writeReg, validOut} = ctrl_q;

  // Halt sequencing and sticky error next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_done_d = halt_done_q;
    err_d       = err_q;
    if (field_en && !bubble_sel && validIn && (regWrtSrcIn == WSRC_ILLEGAL)) begin
      err_d = 1'b1;
    end
    case (state_q)
      ST_RUN: begin
        if (load_en && !flush && validIn && haltIn) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (load_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_DONE;
            halt_done_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        halt_done_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM, drain counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      halt_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_done_q <= halt_done_d;
      err_q       <= err_d;
    end
  end

  assign err      = err_q;
  assign haltDone = halt_done_q;

`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Count edges that load a bubble, saturating at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (field_en && (bubble_sel || !validIn) && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Bubble counter storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (default build, DRAIN_CYCLES=2).
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic        validIn, stall, flush;
  logic [15:0] aluIn, setValIn, reg1In, reg2In, nextPcIn, instrIn;
  logic        memEnIn, memWrtIn, regWrtIn, haltIn;
  logic [2:0]  regWrtSrcIn, writeRegIn;
  logic [15:0] aluOut, setVal, reg1Data, reg2Data, nextPc, instr;
  logic        memEn, memWrt, regWrt, halt;
  logic [2:0]  regWrtSrc, writeReg;
  logic        validOut, err, haltDone;

  int checks   = 0;
  int failures = 0;

  ex_mem_reg #(.DRAIN_CYCLES(2), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .stall(stall), .flush(flush),
    .aluIn(aluIn), .setValIn(setValIn), .reg1In(reg1In), .reg2In(reg2In),
    .nextPcIn(nextPcIn), .instrIn(instrIn),
    .memEnIn(memEnIn), .memWrtIn(memWrtIn), .regWrtIn(regWrtIn), .haltIn(haltIn),
    .regWrtSrcIn(regWrtSrcIn), .writeRegIn(writeRegIn),
    .aluOut(aluOut), .setVal(setVal), .reg1Data(reg1Data), .reg2Data(reg2Data),
    .nextPc(nextPc), .instr(instr),
    .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt), .halt(halt),
    .regWrtSrc(regWrtSrc), .writeReg(writeReg),
    .validOut(validOut), .err(err), .haltDone(haltDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; validIn = 0; stall = 0; flush = 0;
    aluIn = 0; setValIn = 0; reg1In = 0; reg2In = 0; nextPcIn = 0; instrIn = 0;
    memEnIn = 0; memWrtIn = 0; regWrtIn = 0; haltIn = 0;
    regWrtSrcIn = 0; writeRegIn = 0;
    #12;
    chk("rst_alu", aluOut, 16'h0000);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_valid", {15'd0, validOut}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_haltdone", {15'd0, haltDone}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Plain load
    validIn = 1; aluIn = 16'h1234; regWrtIn = 1; writeRegIn = 3'd3;
    instrIn = 16'h1111; memEnIn = 1; regWrtSrcIn = 3'd2; setValIn = 16'h00AA;
    step();
    chk("load_alu", aluOut, 16'h1234);
    chk("load_regwrt", {15'd0, regWrt}, 16'd1);
    chk("load_writereg", {13'd0, writeReg}, 16'd3);
    chk("load_valid", {15'd0, validOut}, 16'd1);
    chk("load_memen", {15'd0, memEn}, 16'd1);
    chk("load_instr", instr, 16'h1111);
    chk("load_setval", setVal, 16'h00AA);

    // Stall holds for three cycles while inputs change
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      aluIn = 16'hABCD + 16'(i); regWrtIn = 0; instrIn = 16'h2222;
      step();
      chk("stall_alu", aluOut, 16'h1234);
      chk("stall_regwrt", {15'd0, regWrt}, 16'd1);
      chk("stall_instr", instr, 16'h1111);
    end

    // Flush beats stall
    flush = 1;
    step();
    chk("flush_memen", {15'd0, memEn}, 16'd0);
    chk("flush_regwrt", {15'd0, regWrt}, 16'd0);
    chk("flush_instr", instr, 16'h0800);
    chk("flush_alu", aluOut, 16'h0000);
    chk("flush_valid", {15'd0, validOut}, 16'd0);

    // Invalid input gates control but still loads data
    stall = 0; flush = 0;
    validIn = 0; memWrtIn = 1; memEnIn = 1; regWrtIn = 1; aluIn = 16'h5555;
    step();
    chk("inv_memwrt", {15'd0, memWrt}, 16'd0);
    chk("inv_regwrt", {15'd0, regWrt}, 16'd0);
    chk("inv_valid", {15'd0, validOut}, 16'd0);
    chk("inv_alu", aluOut, 16'h5555);

    // Halt squashed by flush; FSM stays in RUN
    memWrtIn = 0; memEnIn = 0; regWrtIn = 0;
    validIn = 1; haltIn = 1; flush = 1;
    step();
    chk("hf_halt", {15'd0, halt}, 16'd0);
    chk("hf_haltdone", {15'd0, haltDone}, 16'd0);
    haltIn = 0; flush = 0; aluIn = 16'h7777;
    step();
    chk("hf_run_alu", aluOut, 16'h7777);
    chk("hf_run_valid", {15'd0, validOut}, 16'd1);

    // Sticky error
    regWrtSrcIn = 3'd7;
    step();
    chk("err_set", {15'd0, err}, 16'd1);
    chk("err_src", {13'd0, regWrtSrc}, 16'd7);
    regWrtSrcIn = 3'd1; aluIn = 16'h8888;
    step();
    chk("err_sticky", {15'd0, err}, 16'd1);
    chk("err_noblock_alu", aluOut, 16'h8888);

    // Halt drain with a stall inserted
    haltIn = 1; aluIn = 16'h9999;
    step();
    chk("halt_entry", {15'd0, halt}, 16'd1);
    chk("halt_entry_alu", aluOut, 16'h9999);
    chk("halt_entry_done", {15'd0, haltDone}, 16'd0);
    haltIn = 1; aluIn = 16'hAAAA; regWrtIn = 1; instrIn = 16'h4444;
    step();
    chk("drain1_valid", {15'd0, validOut}, 16'd0);
    chk("drain1_regwrt", {15'd0, regWrt}, 16'd0);
    chk("drain1_alu", aluOut, 16'h0000);
    chk("drain1_instr", instr, 16'h0800);
    chk("drain1_halt", {15'd0, halt}, 16'd0);
    chk("drain1_done", {15'd0, haltDone}, 16'd0);
    stall = 1;
    step();
    chk("drain_stall_done", {15'd0, haltDone}, 16'd0);
    stall = 0;
    step();
    chk("drain2_done", {15'd0, haltDone}, 16'd1);
    chk("drain2_valid", {15'd0, validOut}, 16'd0);
    step();
    chk("done_hold", {15'd0, haltDone}, 16'd1);
    chk("done_alu", aluOut, 16'h0000);
    chk("done_ignore_valid", {15'd0, validOut}, 16'd0);

    // Async reset from DONE drops haltDone without an edge
    #2 rst = 1'b0;
    #1;
    chk("rst_done_haltdone", {15'd0, haltDone}, 16'd0);
    chk("rst_done_err", {15'd0, err}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-drain with err set
    validIn = 1; haltIn = 1; regWrtSrcIn = 3'd7; instrIn = 16'h3333; regWrtIn = 0;
    step();
    chk("mid_err", {15'd0, err}, 16'd1);
    chk("mid_instr", instr, 16'h3333);
    haltIn = 0; regWrtSrcIn = 3'd0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_err", {15'd0, err}, 16'd0);
    chk("mid_rst_haltdone", {15'd0, haltDone}, 16'd0);
    chk("mid_rst_instr", instr, 16'h0800);
    @(negedge clk);
    rst = 1'b1;

    // Back in RUN after reset
    aluIn = 16'hBEEF; instrIn = 16'h5A5A;
    step();
    chk("post_rst_alu", aluOut, 16'hBEEF);
    chk("post_rst_instr", instr, 16'h5A5A);
    step();
    chk("post_rst_done", {15'd0, haltDone}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
